// File: rtl/div_param.sv
// div_param: multi-cycle restoring divider, signed/unsigned, with divide-by-zero and overflow flags.
module div_param #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               dbz_o,
  output logic               ovf_o
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [2:0] {IDLE, BYZERO, RUN, FIX, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] q, r, d, a_mag, b_mag;
  logic [WIDTH:0] trial, diff;
  logic neg_q, neg_r, ovf_q, last;
  always_comb begin
    a_mag = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    b_mag = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    trial = {r, q[WIDTH-1]};
    diff = trial - {1'b0, d};
    last = cnt == CW'(WIDTH - 1);
    state_n = state;
    case (state)
      IDLE:    if (start_i && !annul_i) state_n = (opdata2_i == '0) ? BYZERO : RUN;
      BYZERO:  state_n = annul_i ? IDLE : DONE;
      RUN:     state_n = annul_i ? IDLE : last ? FIX : RUN;
      FIX:     state_n = annul_i ? IDLE : DONE;
      DONE:    if (ready_o && !start_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign busy_o = state inside {RUN, BYZERO, FIX};
  // ready_o rises on the first DONE edge so the result is presented a full cycle after it is formed
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      q <= '0;
      r <= '0;
      d <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      ovf_q <= 1'b0;
      result_o <= '0;
      ready_o <= 1'b0;
      dbz_o <= 1'b0;
      ovf_o <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && state_n == RUN) begin
        q <= a_mag;
        d <= b_mag;
        r <= '0;
        cnt <= '0;
        neg_q <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
        neg_r <= signed_div_i & opdata1_i[WIDTH-1];
        ovf_q <= signed_div_i && opdata1_i == {1'b1, {(WIDTH-1){1'b0}}} && &opdata2_i;
      end
      if (state == RUN && !annul_i) begin
        cnt <= cnt + 1'b1;
        q <= {q[WIDTH-2:0], ~diff[WIDTH]};
        r <= diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
      end
      if (state == FIX && !annul_i) begin
        result_o <= {neg_r ? -r : r, neg_q ? -q : q};
        ovf_o <= ovf_q;
      end
      if (state == BYZERO && !annul_i) dbz_o <= 1'b1;
      if (state == DONE && ready_o && !start_i) begin
        result_o <= '0;
        ready_o <= 1'b0;
        dbz_o <= 1'b0;
        ovf_o <= 1'b0;
      end else if (state == DONE) ready_o <= 1'b1;
    end
  end
endmodule

// File: doc/div_param.md
DIV_PARAM -- requirements
Module: div_param

Interface
REQ-001 Parameter: WIDTH, default 32, operand width in bits; legal range 4..64.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 signed_div_i  input  1  1 = two's-complement divide, 0 = unsigned; sampled with start_i.
REQ-005 opdata1_i  input  WIDTH  dividend; sampled with start_i.
REQ-006 opdata2_i  input  WIDTH  divisor; sampled with start_i.
REQ-007 start_i  input  1  request; level-held by the requester until ready_o is seen.
REQ-008 annul_i  input  1  abort of the current operation.
REQ-009 result_o  output  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}.
REQ-010 ready_o  output  1  result_o valid.
REQ-011 busy_o  output  1  high in RUN, BYZERO and FIX.
REQ-012 dbz_o  output  1  divide-by-zero flag; qualified by ready_o.
REQ-013 ovf_o  output  1  signed overflow flag (MIN / -1); qualified by ready_o.

Function
REQ-014 States SHALL be IDLE, BYZERO, RUN, FIX and DONE.
REQ-015 IDLE, start_i=1, annul_i=0, divisor=0: the edge SHALL go to BYZERO.
REQ-016 IDLE, start_i=1, annul_i=0, divisor!=0: the edge SHALL latch operands and go to RUN with the bit counter at 0.
REQ-017 On that same edge, for signed operation, the block SHALL latch the magnitudes of both operands and the two sign bits.
REQ-018 IDLE, start_i=1 and annul_i=1 on the same edge: annul SHALL win and the block SHALL stay in IDLE.
REQ-019 RUN, per edge: restoring shift-subtract, one quotient bit per edge, counter +1.
REQ-020 RUN SHALL last exactly WIDTH edges, then go to FIX.
REQ-021 Counter width SHALL be clog2(WIDTH+1); the counter SHALL never wrap.
REQ-022 FIX, one edge: quotient SHALL be negated when signed and the operand signs differ.
REQ-023 FIX, same edge: remainder SHALL be negated when signed and the dividend is negative.
REQ-024 FIX SHALL then go to DONE.
REQ-025 BYZERO, one edge: result SHALL be 0, dbz_o=1, then DONE.
REQ-026 ovf_o SHALL be 1 when signed, dividend = 2^(WIDTH-1) pattern and divisor = all-ones.
REQ-027 In the ovf_o case, result SHALL be quotient = 2^(WIDTH-1) pattern and remainder = 0, produced by the normal datapath.
REQ-028 DONE: ready_o=1; result_o, dbz_o and ovf_o SHALL be held constant.
REQ-029 DONE, start_i=0: next edge SHALL go to IDLE and clear ready_o, result_o, dbz_o and ovf_o to 0.
REQ-030 DONE, start_i=1: the block SHALL stay in DONE; no new operation starts until start_i has been low for one edge.
REQ-031 Latency, nonzero divisor: ready_o SHALL first be high after edge E0+WIDTH+2, where E0 is the sampling edge.
REQ-032 Latency, zero divisor: ready_o SHALL first be high after edge E0+2.
REQ-033 annul_i=1 in RUN, BYZERO or FIX: next edge SHALL go to IDLE with outputs 0 and ready_o never asserted.
REQ-034 annul_i in DONE or IDLE SHALL have no effect beyond REQ-018.
REQ-035 Operand input changes after E0 SHALL NOT affect the operation in progress.
REQ-036 busy_o SHALL be 0 in IDLE and DONE.

Reset
REQ-037 rst=1 at any edge, in any state including mid-RUN, SHALL force IDLE, counter 0 and all outputs 0.
REQ-038 rst SHALL take priority over start_i and annul_i.
REQ-039 No output SHALL depend combinationally on rst; all outputs SHALL be registered or decoded from registered state.

Verification
REQ-040 WIDTH=32, unsigned 100/7, start held: ready_o high after edge E0+34, result_o = {32'd2, 32'd14}; drop start -> IDLE, outputs 0.
REQ-041 WIDTH=32, signed -100/7: result_o = {32'hFFFFFFFE, 32'hFFFFFFF2}; signed 100/-7: result_o = {32'd2, 32'hFFFFFFF2}.
REQ-042 WIDTH=8, divisor 0, dividend 8'h55: ready_o after edge E0+2, dbz_o=1, result_o=16'h0000; WIDTH=8 signed 8'h80/8'hFF: quotient 8'h80, remainder 0, ovf_o=1.
REQ-043 WIDTH=32, annul_i pulsed at RUN edge 10: IDLE next edge, ready_o stays 0; a new start then yields the correct result with full latency.
REQ-044 WIDTH=16, rst asserted mid-RUN: all outputs 0 next edge; start_i held through DONE: no restart until start_i low for one edge.
REQ-045 Random regression on WIDTH in {8, 32}, both signed modes: every result SHALL match the reference-model quotient and remainder, and every latency SHALL equal REQ-031/REQ-032.
